fdiv_mul_arbiter: RTL and testbench



---
 rtl/fdiv_mul_arbiter.sv | 99 +++++++++
 tb/tb_fdiv_mul_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fdiv_mul_arbiter.sv
// Round-robin arbiter sharing the fdiv mantissa multiplier between NREQ requesters.
// Optional FDIV_MUL_ARB_STATS_EN adds issue/contention counters.
module fdiv_mul_arbiter #(
  parameter int NREQ = 2,
  parameter int LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_x,
  input  logic [32*NREQ-1:0]   req_y,
  output logic [31:0]          mul_x,
  output logic [31:0]          mul_y,
  input  logic [31:0]          mul_res,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_data
`ifdef FDIV_MUL_ARB_STATS_EN
  ,
  output logic [31:0]          stat_busy,
  output logic [31:0]          stat_contend
`endif
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0]          rr_ptr;
  logic [IDW-1:0]          gnt_id;
  logic [IDW-1:0]          idx;
  logic                    issue;
  logic [LAT-1:0]          vld_p;
  logic [LAT-1:0][IDW-1:0] id_p;

  // Scanning downward and overwriting leaves the first valid requester at or above rr_ptr.
  always_comb begin
    issue     = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    req_ready = '0;
    if (rstn) begin
      for (int off = NREQ - 1; off >= 0; off--) begin
        idx = IDW'((int'(rr_ptr) + off) % NREQ);
        if (req_valid[idx]) begin
          issue  = 1'b1;
          gnt_id = idx;
        end
      end
    end
    if (issue) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    mul_x = '0;
    mul_y = '0;
    if (issue) begin
      mul_x = req_x[32*gnt_id +: 32];
      mul_y = req_y[32*gnt_id +: 32];
    end
  end

  // Stage 0 captures the issue; the last stage lines up with mul_res.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr <= '0;
      vld_p  <= '0;
    end else begin
      if (issue) rr_ptr <= IDW'((int'(gnt_id) + 1) % NREQ);
      vld_p[0] <= issue;
      for (int s = 1; s < LAT; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  always_ff @(posedge clk) begin
    id_p[0] <= gnt_id;
    for (int s = 1; s < LAT; s++) id_p[s] <= id_p[s-1];
  end

  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    if (rstn && vld_p[LAT-1]) begin
      resp_valid[id_p[LAT-1]] = 1'b1;
      resp_data               = mul_res;
    end
  end

`ifdef FDIV_MUL_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_busy    <= '0;
      stat_contend <= '0;
    end else begin
      if (issue) stat_busy <= stat_busy + 32'd1;
      if ($countones(req_valid) > 1) stat_contend <= stat_contend + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fdiv_mul_arbiter.sv
// Directed bench: NREQ=2/LAT=1 and NREQ=4/LAT=3 instances, each with an XOR stub multiplier.
module tb_fdiv_mul_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  int   checks = 0;
  int   errors = 0;

  logic [1:0]   va, ra, rva;
  logic [63:0]  xa, ya;
  logic [31:0]  mxa, mya, resa, rda;
  logic [3:0]   vb, rb, rvb;
  logic [127:0] xb, yb;
  logic [31:0]  mxb, myb, resb, rdb;
  logic [31:0]  pa;
  logic [2:0][31:0] pb;
`ifdef FDIV_MUL_ARB_STATS_EN
  logic [31:0] sba, sca, sbb, scb;
`endif

  fdiv_mul_arbiter #(.NREQ(2), .LAT(1)) u_a (
    .clk(clk), .rstn(rstn), .req_valid(va), .req_ready(ra),
    .req_x(xa), .req_y(ya), .mul_x(mxa), .mul_y(mya), .mul_res(resa),
    .resp_valid(rva), .resp_data(rda)
`ifdef FDIV_MUL_ARB_STATS_EN
    , .stat_busy(sba), .stat_contend(sca)
`endif
  );

  fdiv_mul_arbiter #(.NREQ(4), .LAT(3)) u_b (
    .clk(clk), .rstn(rstn), .req_valid(vb), .req_ready(rb),
    .req_x(xb), .req_y(yb), .mul_x(mxb), .mul_y(myb), .mul_res(resb),
    .resp_valid(rvb), .resp_data(rdb)
`ifdef FDIV_MUL_ARB_STATS_EN
    , .stat_busy(sbb), .stat_contend(scb)
`endif
  );

  // Stub multipliers: x ^ y delayed by LAT cycles.
  always_ff @(posedge clk) begin
    pa <= mxa ^ mya;
    pb <= {pb[1:0], mxb ^ myb};
  end
  assign resa = pa;
  assign resb = pb[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; va = '0; vb = '0; xa = '0; ya = '0; xb = '0; yb = '0;

    // Reset: requests present but nothing may be granted.
    cyc(); va = 2'b11; vb = 4'b1111; #2;
    chk("rst_ready_a", 32'(ra), 32'h0);
    chk("rst_ready_b", 32'(rb), 32'h0);
    chk("rst_mulx_a", mxa, 32'h0);
    chk("rst_muly_b", myb, 32'h0);
    chk("rst_rv_a", 32'(rva), 32'h0);
    chk("rst_rd_a", rda, 32'h0);
    chk("rst_rv_b", 32'(rvb), 32'h0);

    // Single request on A in cycle 5 after release.
    cyc(); rstn = 1'b1; va = '0; vb = '0; #2;
    chk("s1_idle_ready", 32'(ra), 32'h0);
    repeat (5) cyc();
    va = 2'b01; xa[31:0] = 32'h3FC00000; ya[31:0] = 32'h40000000; #2;
    chk("s1_ready", 32'(ra), 32'h1);
    chk("s1_mulx", mxa, 32'h3FC00000);
    chk("s1_muly", mya, 32'h40000000);
    chk("s1_rv_early", 32'(rva), 32'h0);
    cyc(); va = '0; #2;
    chk("s1_rv", 32'(rva), 32'h1);
    chk("s1_rd", rda, 32'h7FC00000);
    chk("s1_mulx_idle", mxa, 32'h0);
    cyc(); #2;
    chk("s1_rv_end", 32'(rva), 32'h0);
    chk("s1_rd_end", rda, 32'h0);

    // Contention on A after a fresh reset: 10 cycles both valid, then idle.
    cyc(); rstn = 1'b0; #2;
    cyc(); rstn = 1'b1; xa = {32'h4, 32'h1}; ya = {32'h8, 32'h2}; va = 2'b11;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) cyc();
      #2;
      chk("s2_ready", 32'(ra), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("s2_mulx", mxa, (k % 2 == 0) ? 32'h1 : 32'h4);
      chk("s2_rv", 32'(rva), (k == 0) ? 32'h0 : ((k % 2 == 1) ? 32'h1 : 32'h2));
      chk("s2_rd", rda, (k == 0) ? 32'h0 : ((k % 2 == 1) ? 32'h3 : 32'hC));
    end
    cyc(); va = '0; #2;
    chk("s2_rv_tail", 32'(rva), 32'h2);
    chk("s2_rd_tail", rda, 32'hC);
    chk("s2_ready_idle", 32'(ra), 32'h0);
    repeat (4) cyc();
    #2;
    chk("s2_rv_quiet", 32'(rva), 32'h0);
`ifdef FDIV_MUL_ARB_STATS_EN
    chk("stat_busy", sba, 32'd10);
    chk("stat_contend", sca, 32'd10);
`endif

    // Round-robin wrap on B: only req1 and req3 valid.
    cyc();
    xb = '0; yb = '0;
    xb[63:32] = 32'h11;   yb[63:32] = 32'h100;
    xb[127:96] = 32'h3300; yb[127:96] = 32'h33;
    vb = 4'b1010;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) cyc();
      if (k >= 6) vb = '0;
      #2;
      chk("s3_ready", 32'(rb), (k < 6) ? ((k % 2 == 0) ? 32'h2 : 32'h8) : 32'h0);
      chk("s3_mulx", mxb, (k < 6) ? ((k % 2 == 0) ? 32'h11 : 32'h3300) : 32'h0);
      chk("s3_rv", 32'(rvb), (k >= 3 && k < 9) ? (((k - 3) % 2 == 0) ? 32'h2 : 32'h8) : 32'h0);
      chk("s3_rd", rdb, (k >= 3 && k < 9) ? (((k - 3) % 2 == 0) ? 32'h111 : 32'h3333) : 32'h0);
    end

    // Idle on B with rr_ptr left at 2 by a single req1 issue.
    cyc(); vb = 4'b0010; #2;
    chk("s4_ready", 32'(rb), 32'h2);
    for (int k = 0; k < 20; k++) begin
      cyc(); vb = '0; #2;
      chk("idle_mulx", mxb, 32'h0);
      chk("idle_muly", myb, 32'h0);
      chk("idle_ready", 32'(rb), 32'h0);
      chk("idle_rv", 32'(rvb), (k == 2) ? 32'h2 : 32'h0);
      chk("idle_rd", rdb, (k == 2) ? 32'h111 : 32'h0);
    end
    cyc(); vb = 4'b1111; #2;
    chk("idle_rr_kept", 32'(rb), 32'h4);

    // Reset mid-flight on B: issue to req0, then reset; its response must vanish.
    cyc(); vb = 4'b0001; xb[31:0] = 32'hAAAA0000; yb[31:0] = 32'h0000BBBB; #2;
    chk("mf_ready", 32'(rb), 32'h1);
    chk("mf_mulx", mxb, 32'hAAAA0000);
    cyc(); rstn = 1'b0; #2;
    chk("mf_rst_ready", 32'(rb), 32'h0);
    chk("mf_rst_mulx", mxb, 32'h0);
    chk("mf_rst_rv", 32'(rvb), 32'h0);
    cyc(); rstn = 1'b1; vb = '0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) cyc();
      #2;
      chk("mf_rv", 32'(rvb), 32'h0);
      chk("mf_rd", rdb, 32'h0);
    end
    cyc(); vb = 4'b1111; #2;
    chk("mf_next_grant", 32'(rb), 32'h1);
    cyc(); vb = '0; #2;
`ifdef FDIV_MUL_ARB_STATS_EN
    chk("stat_busy_b", sbb, 32'd1);
    chk("stat_contend_b", scb, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
